// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, scheduler state encoding and pixel address helper
// for the back-buffer write scheduler.
package fb_pkg;

  localparam int FB_W     = 128;
  localparam int FB_H     = 96;
  localparam int FB_DEPTH = 12288;
  localparam int ADDR_W   = 14;
  localparam int PIX_W    = 8;
  localparam int COORD_W  = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } fb_state_t;

  // Row-major address with a 128-pixel stride: y*128 + x
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] x,
                                                 input logic [COORD_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/frame_write_scheduler_if.sv
// Pixel requester handshake plus the frame-buffer write port driven by the scheduler.
interface frame_write_scheduler_if #(
  parameter int N_REQ = 3
);

  logic [N_REQ-1:0]                     req_valid;
  logic [fb_pkg::COORD_W*N_REQ-1:0]     req_x;
  logic [fb_pkg::COORD_W*N_REQ-1:0]     req_y;
  logic [fb_pkg::PIX_W*N_REQ-1:0]       req_color;
  logic [N_REQ-1:0]                     req_ready;
  logic [fb_pkg::ADDR_W-1:0]            addr_write;
  logic [fb_pkg::PIX_W-1:0]             data_write;
  logic                                 wr_en;

  modport master (
    output req_valid, req_x, req_y, req_color,
    input  req_ready, addr_write, data_write, wr_en
  );

  modport slave (
    input  req_valid, req_x, req_y, req_color,
    output req_ready, addr_write, data_write, wr_en
  );

endinterface

// File: rtl/frame_write_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: the search starts just after the last granted requester
// and wraps; the pointer advances only when the caller reports a completed transfer.
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic             enable,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] last_ptr
);

  logic [PTR_W-1:0] last_ptr_r;
  logic [N-1:0]     grant_s;
  logic [PTR_W-1:0] grant_idx_s;
  logic             found_s;

  // First requesting index after the pointer, wrapping around
  always_comb begin
    grant_s     = '0;
    grant_idx_s = last_ptr_r;
    found_s     = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int   idx;
      logic hit;
      idx          = (int'(last_ptr_r) + off) % N;
      hit          = enable && !found_s && req[idx];
      grant_s[idx] = grant_s[idx] | hit;
      grant_idx_s  = hit ? PTR_W'(idx) : grant_idx_s;
      found_s      = found_s | hit;
    end
  end

  // Last-grant pointer; reset value makes requester 0 the first candidate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_ptr_r <= PTR_W'(N - 1);
    end else if (advance) begin
      last_ptr_r <= grant_idx_s;
    end else begin
      last_ptr_r <= last_ptr_r;
    end
  end

  assign grant    = grant_s;
  assign last_ptr = last_ptr_r;

endmodule

// File: rtl/frame_write_scheduler.sv
// Back-buffer write scheduler: clears the buffer after each swap, then arbitrates
// pixel requesters onto the single registered write port.
module frame_write_scheduler
  import fb_pkg::*;
#(
  parameter int               N_REQ       = 3,
  parameter logic [PIX_W-1:0] BG_COLOR    = 8'h00,
  parameter logic [PIX_W-1:0] TRANSPARENT = 8'hE3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_start,
  frame_write_scheduler_if.slave  bus,
  output logic                    clear_done,
  output logic                    overrun
);

  fb_state_t          state_r;
  logic [ADDR_W-1:0]  cnt_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [PIX_W-1:0]   data_r;
  logic               wr_en_r;
  logic               clear_done_r;
  logic               overrun_r;

  logic [N_REQ-1:0]   grant_s;
  logic               arb_en_s;
  logic               transfer_s;
  logic [COORD_W-1:0] sel_x_s;
  logic [COORD_W-1:0] sel_y_s;
  logic [PIX_W-1:0]   sel_c_s;
  logic               pix_vis_s;

  // A swap in SERVE takes priority, so no requester is granted in that cycle
  assign arb_en_s   = (state_r == SERVE) && !frame_start;
  assign transfer_s = |grant_s;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (bus.req_valid),
    .advance  (transfer_s),
    .enable   (arb_en_s),
    .grant    (grant_s),
    .last_ptr ()
  );

  // Select the granted requester's pixel fields
  always_comb begin
    sel_x_s = '0;
    sel_y_s = '0;
    sel_c_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_x_s = grant_s[i] ? bus.req_x[COORD_W*i +: COORD_W]   : sel_x_s;
      sel_y_s = grant_s[i] ? bus.req_y[COORD_W*i +: COORD_W]   : sel_y_s;
      sel_c_s = grant_s[i] ? bus.req_color[PIX_W*i +: PIX_W]   : sel_c_s;
    end
    pix_vis_s = (sel_c_s != TRANSPARENT) && (sel_y_s < COORD_W'(FB_H));
  end

  // Scheduler state machine with registered write port and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      addr_r       <= '0;
      data_r       <= '0;
      wr_en_r      <= 1'b0;
      clear_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      clear_done_r <= 1'b0;
      overrun_r    <= 1'b0;
      wr_en_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (frame_start) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          if (frame_start) begin
            cnt_r     <= '0;
            overrun_r <= 1'b1;
          end else begin
            addr_r  <= cnt_r;
            data_r  <= BG_COLOR;
            wr_en_r <= 1'b1;
            if (cnt_r == ADDR_W'(FB_DEPTH - 1)) begin
              state_r      <= SERVE;
              clear_done_r <= 1'b1;
              cnt_r        <= '0;
            end else begin
              cnt_r <= cnt_r + 14'd1;
            end
          end
        end
        SERVE: begin
          if (frame_start) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
          end else if (transfer_s && pix_vis_s) begin
            // Dropped pixels leave addr/data untouched; RAM rewrites stay idempotent
            addr_r  <= pix_addr(sel_x_s, sel_y_s);
            data_r  <= sel_c_s;
            wr_en_r <= 1'b1;
          end else begin
            state_r <= SERVE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready  = grant_s;
  assign bus.addr_write = addr_r;
  assign bus.data_write = data_r;
  assign bus.wr_en      = wr_en_r;
  assign clear_done     = clear_done_r;
  assign overrun        = overrun_r;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Directed-plus-random bench for frame_write_scheduler against a behavioural
// round-robin / pixel-write model.
module tb_frame_write_scheduler;

  localparam logic [7:0] TRANSP = 8'hE3;

  logic clk;
  logic reset;
  logic frame_start;
  logic clear_done;
  logic overrun;

  int checks = 0;
  int errors = 0;

  int          exp_last;
  logic [13:0] exp_addr;
  logic [7:0]  exp_data;

  frame_write_scheduler_if #(.N_REQ(3)) bus ();

  frame_write_scheduler #(
    .N_REQ       (3),
    .BG_COLOR    (8'h00),
    .TRANSPARENT (8'hE3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bus         (bus),
    .clear_done  (clear_done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs `count` clear cycles expecting addresses first.., random requests never granted
  task automatic clear_cycles(input int first, input int count);
    int bad;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      bus.req_valid = 3'($urandom_range(0, 7));
      #1;
      if (bus.req_ready !== 3'b000) bad++;
      @(posedge clk);
      #1;
      if (bus.wr_en !== 1'b1) bad++;
      if (bus.addr_write !== 14'(first + i)) bad++;
      if (bus.data_write !== 8'h00) bad++;
      if (clear_done !== ((first + i) == 12287)) bad++;
      if (overrun !== 1'b0) bad++;
    end
    bus.req_valid = 3'b000;
    chk("clear_seq_bad", 32'(bad), 32'd0);
  endtask

  // One SERVE cycle: drive requests, check the grant, then check the write one edge later
  task automatic serve_cycle(input logic [2:0] v, input logic [20:0] xs,
                             input logic [20:0] ys, input logic [23:0] cs);
    int         gi;
    logic [2:0] exp_g;
    logic       exp_wr;
    int         px, py;
    logic [7:0] pc;
    bus.req_valid = v;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.req_color = cs;
    #1;
    gi    = -1;
    exp_g = 3'b000;
    for (int off = 1; off <= 3; off++) begin
      int j;
      j = (exp_last + off) % 3;
      if (gi < 0 && v[j]) gi = j;
    end
    exp_wr = 1'b0;
    if (gi >= 0) begin
      exp_g[gi] = 1'b1;
      exp_last  = gi;
      px = int'(xs[7*gi +: 7]);
      py = int'(ys[7*gi +: 7]);
      pc = cs[8*gi +: 8];
      if (pc != TRANSP && py < 96) begin
        exp_wr   = 1'b1;
        exp_addr = 14'(py * 128 + px);
        exp_data = pc;
      end
    end
    chk("grant", 32'(bus.req_ready), 32'(exp_g));
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    chk("serve_wr_en", 32'(bus.wr_en), 32'(exp_wr));
    chk("serve_addr", 32'(bus.addr_write), 32'(exp_addr));
    chk("serve_data", 32'(bus.data_write), 32'(exp_data));
    chk("serve_no_pulse", 32'({clear_done, overrun}), 32'd0);
  endtask

  task automatic rand_pixels(output logic [20:0] xs, output logic [20:0] ys,
                             output logic [23:0] cs, input bit visible);
    for (int i = 0; i < 3; i++) begin
      xs[7*i +: 7] = 7'($urandom_range(0, 127));
      ys[7*i +: 7] = visible ? 7'($urandom_range(0, 95)) : 7'($urandom_range(0, 127));
      if (visible) cs[8*i +: 8] = 8'($urandom_range(0, 226));
      else         cs[8*i +: 8] = ($urandom_range(0, 7) == 0) ? TRANSP : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_addr"},  32'(bus.addr_write), 32'd0);
    chk({tag, "_data"},  32'(bus.data_write), 32'd0);
    chk({tag, "_pulses"}, 32'({clear_done, overrun}), 32'd0);
  endtask

  initial begin
    logic [20:0] xs, ys;
    logic [23:0] cs;
    logic [13:0] held_addr;

    reset         = 1'b1;
    frame_start   = 1'b0;
    bus.req_valid = 3'b000;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_color = '0;
    exp_last      = 2;
    exp_addr      = 14'd0;
    exp_data      = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = 3'b111;
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // IDLE ignores requests until a swap arrives
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("idle_ready", 32'(bus.req_ready), 32'd0);
      chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
    end
    bus.req_valid = 3'b000;

    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("fs_edge_wr_en", 32'(bus.wr_en), 32'd0);
    clear_cycles(0, 12288);
    exp_addr = 14'd12287;
    exp_data = 8'h00;

    // Requester 1 writes (5,3) colour 1C -> address 389
    serve_cycle(3'b010, {7'd0, 7'd5, 7'd0}, {7'd0, 7'd3, 7'd0}, {8'h00, 8'h1C, 8'h00});
    chk("pix389_addr", 32'(bus.addr_write), 32'd389);
    chk("pix389_data", 32'(bus.data_write), 32'h1C);

    // All requesters valid continuously: rotate one grant per clock
    for (int k = 0; k < 6; k++) begin
      rand_pixels(xs, ys, cs, 1'b1);
      serve_cycle(3'b111, xs, ys, cs);
      chk("rr_all_wr_en", 32'(bus.wr_en), 32'd1);
    end

    // Transparent and off-screen pixels are consumed but not written
    held_addr = bus.addr_write;
    serve_cycle(3'b001, {7'd0, 7'd0, 7'd9}, {7'd0, 7'd0, 7'd10}, {8'h00, 8'h00, TRANSP});
    serve_cycle(3'b100, {7'd4, 7'd0, 7'd0}, {7'd100, 7'd0, 7'd0}, {8'h55, 8'h00, 8'h00});
    chk("drop_addr_hold", 32'(bus.addr_write), 32'(held_addr));

    for (int k = 0; k < 300; k++) begin
      rand_pixels(xs, ys, cs, 1'b0);
      serve_cycle(3'($urandom_range(0, 7)), xs, ys, cs);
    end

    // Swap during SERVE blocks the pending grant and restarts the clear
    bus.req_valid = 3'b111;
    frame_start   = 1'b1;
    #1;
    chk("fs_serve_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    frame_start   = 1'b0;
    bus.req_valid = 3'b000;
    chk("fs_serve_wr_en", 32'(bus.wr_en), 32'd0);
    clear_cycles(0, 5000);

    // Swap mid-clear: overrun pulse, then a complete clear from address 0
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("overrun_pulse", 32'(overrun), 32'd1);
    chk("overrun_wr_en", 32'(bus.wr_en), 32'd0);
    clear_cycles(0, 12288);
    exp_addr = 14'd12287;
    exp_data = 8'h00;

    for (int k = 0; k < 20; k++) begin
      rand_pixels(xs, ys, cs, 1'b0);
      serve_cycle(3'($urandom_range(0, 7)), xs, ys, cs);
    end

    // Reset mid-SERVE with requests pending clears every output at once
    bus.req_valid = 3'b111;
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_last = 2;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("post_reset_ready", 32'(bus.req_ready), 32'd0);
      chk("post_reset_wr_en", 32'(bus.wr_en), 32'd0);
    end
    bus.req_valid = 3'b000;

    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    clear_cycles(0, 12288);
    exp_addr = 14'd12287;
    exp_data = 8'h00;

    // Pointer was reset, so requester 0 wins first
    rand_pixels(xs, ys, cs, 1'b1);
    serve_cycle(3'b111, xs, ys, cs);
    chk("first_after_reset", 32'(exp_last), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
